// File: rtl/page_unshifter_pkg.sv
// Shared definitions for the rho un-rotation path: page geometry, the 5x5
// rotation table and the controller state encoding.
package page_unshifter_pkg;

    localparam int LEN_DATA  = 25;
    localparam int SIZE_PAGE = 64;

    // RHO[x][y]: rotation applied by the forward shifter to lane (x,y)
    localparam int RHO [5][5] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Lane l sits at bit 5*y+x of a slice; lanes outside the 5x5 grid get no rotation.
    function automatic int rho_of_lane(input int lane);
        if (lane < 0 || lane >= 25) begin
            return 0;
        end
        return RHO[lane % 5][lane / 5];
    endfunction

endpackage

// File: rtl/page_buffer.sv
// One page of slices: written a whole slice at a time, read back one bit per
// lane where every lane may address a different slice.
module page_buffer
    import page_unshifter_pkg::*;
#(
    parameter int LEN_DATA  = page_unshifter_pkg::LEN_DATA,
    parameter int SIZE_PAGE = page_unshifter_pkg::SIZE_PAGE,
    localparam int ZW       = $clog2(SIZE_PAGE)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ZW-1:0]                waddr,
    input  logic [LEN_DATA-1:0]          wdata,
    input  logic [LEN_DATA-1:0][ZW-1:0]  raddr,
    output logic [LEN_DATA-1:0]          rbits
);

    logic [LEN_DATA-1:0] mem [SIZE_PAGE];

    // Storage is deliberately not reset; a page is always fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rbits = '0;
        for (int l = 0; l < LEN_DATA; l++) begin
            rbits[l] = mem[raddr[l]][l];
        end
    end

endmodule

// File: rtl/page_unshifter.sv
// Inverse rho rotation: buffers a page of rotated slices, then replays it with
// each lane rotated back so output slice z carries stored bit (z + r) mod SIZE_PAGE.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; all other inputs ignored
//   LOAD    | in_ready high, slices written to buffer in order z
//   EMIT    | out_valid high, restored slices replayed in order z
//   FIN     | done pulse after the final page, then back to IDLE
module page_unshifter
    import page_unshifter_pkg::*;
#(
    parameter int LEN_DATA  = page_unshifter_pkg::LEN_DATA,
    parameter int SIZE_PAGE = page_unshifter_pkg::SIZE_PAGE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [LEN_DATA-1:0] data_in,
    input  logic                page_last,
    output logic                in_ready,
    output logic                out_valid,
    output logic [LEN_DATA-1:0] data_out,
    output logic                one_done,
    output logic                done
);

    localparam int ZW = $clog2(SIZE_PAGE);
    localparam logic [ZW-1:0] Z_LAST = ZW'(SIZE_PAGE - 1);

    state_t                       state_q, state_d;
    logic [ZW-1:0]                z_q, z_d;
    logic                         last_q, last_d;
    logic                         we;
    logic [ZW-1:0]                base;
    logic [LEN_DATA-1:0][ZW-1:0]  raddr;
    logic [LEN_DATA-1:0]          rbits;
    logic [LEN_DATA-1:0]          slice;
    logic [LEN_DATA-1:0]          data_d;
    logic                         ready_d, valid_d, one_done_d, done_d;

    page_buffer #(
        .LEN_DATA  (LEN_DATA),
        .SIZE_PAGE (SIZE_PAGE)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (z_q),
        .wdata (data_in),
        .raddr (raddr),
        .rbits (rbits)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered, so the slice presented next cycle is computed now:
    // slice 0 on the final load transfer, otherwise the slice after the current one.
    always_comb begin
        state_d    = state_q;
        z_d        = z_q;
        last_d     = last_q;
        we         = 1'b0;
        base       = z_q + ZW'(1);
        ready_d    = 1'b0;
        valid_d    = 1'b0;
        one_done_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    z_d     = '0;
                    last_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                ready_d = 1'b1;
                if (in_valid) begin
                    we  = 1'b1;
                    z_d = z_q + ZW'(1);
                    if (z_q == Z_LAST) begin
                        state_d = ST_EMIT;
                        last_d  = page_last;
                        ready_d = 1'b0;
                        valid_d = 1'b1;
                        base    = '0;
                    end
                end
            end
            ST_EMIT: begin
                z_d = z_q + ZW'(1);
                if (z_q == Z_LAST) begin
                    state_d = last_q ? ST_FIN : ST_LOAD;
                    ready_d = !last_q;
                    done_d  = last_q;
                end else begin
                    valid_d    = 1'b1;
                    one_done_d = (z_q == Z_LAST - ZW'(1));
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The slice being written this cycle is not in the buffer yet, so forward it.
    always_comb begin
        raddr = '0;
        slice = '0;
        for (int l = 0; l < LEN_DATA; l++) begin
            raddr[l] = base + ZW'(rho_of_lane(l) % SIZE_PAGE);
            slice[l] = (we && raddr[l] == z_q) ? data_in[l] : rbits[l];
        end
        data_d = valid_d ? slice : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_q       <= '0;
            last_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            one_done  <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
        end else begin
            z_q       <= z_d;
            last_q    <= last_d;
            in_ready  <= ready_d;
            out_valid <= valid_d;
            one_done  <= one_done_d;
            done      <= done_d;
            data_out  <= data_d;
        end
    end

endmodule

// File: tb/tb_page_unshifter.sv
// Scoreboard bench for page_unshifter: stimulus pushes expected slices, a
// negedge monitor pops and compares them and tracks one_done/done pulses.
module tb_page_unshifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [24:0] data_in;
    logic        page_last;
    logic        in_ready;
    logic        out_valid;
    logic [24:0] data_out;
    logic        one_done;
    logic        done;

    page_unshifter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .page_last (page_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .one_done  (one_done),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] d;
        bit          od;
        bit          fin;
    } exp_t;

    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    bit          pend_done = 0;
    logic [24:0] page_in  [64];
    logic [24:0] page_exp [64];
    logic [24:0] orig     [64];

    // rotation table as rows y = 0..4, columns x = 0..4
    int rho_t [5][5] = '{
        '{ 0,  1, 62, 28, 27},
        '{36, 44,  6, 55, 20},
        '{ 3, 10, 43, 25, 39},
        '{41, 45, 15, 21,  8},
        '{18,  2, 61, 56, 14}
    };

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            pend_done = 0;
        end else begin
            if (pend_done || done) begin
                n_vec++;
                if (done !== pend_done) begin
                    n_err++;
                    $display("FAIL done_pulse: got %b want %b at %0t", done, pend_done, $time);
                end
            end
            if (done === 1'b1) n_done++;
            pend_done = 0;
            if (out_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: data %h with empty scoreboard at %0t", data_out, $time);
                end else begin
                    e = sb.pop_front();
                    if (data_out !== e.d || one_done !== e.od) begin
                        n_err++;
                        $display("FAIL slice: got data %h one_done %b want data %h one_done %b at %0t",
                                 data_out, one_done, e.d, e.od, $time);
                    end
                    pend_done = e.od && e.fin;
                end
            end else begin
                n_vec++;
                if (data_out !== 25'd0 || one_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_out: got data %h one_done %b want 0 0 at %0t", data_out, one_done, $time);
                end
            end
        end
    end

    task automatic clear_page();
        for (int z = 0; z < 64; z++) begin
            page_in[z]  = 25'd0;
            page_exp[z] = 25'd0;
        end
    endtask

    // forward rho shifter: rotated slice z holds original bit (z - r) mod 64
    task automatic rotate_random();
        for (int z = 0; z < 64; z++) orig[z] = 25'($urandom());
        for (int z = 0; z < 64; z++) begin
            for (int l = 0; l < 25; l++) begin
                page_in[z][l] = orig[(z - rho_t[l / 5][l % 5] + 64) % 64][l];
            end
            page_exp[z] = orig[z];
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_page(input bit fin, input int stall_z, input int stall_len,
                             input int glitch_z, input int start_z);
        int g;
        for (int z = 0; z < 64; z++) sb.push_back('{page_exp[z], z == 63, fin});
        for (int z = 0; z < 64; z++) begin
            if (z == stall_z) begin
                in_valid  = 1'b0;
                page_last = 1'b1;
                data_in   = 25'($urandom());
                repeat (stall_len) begin @(posedge clk); #1; end
            end
            in_valid  = 1'b1;
            data_in   = page_in[z];
            page_last = (z == 63) ? fin : (z == glitch_z);
            start     = (z == start_z);
            g = 0;
            while (!in_ready && g < 200) begin
                @(posedge clk); #1;
                g++;
            end
            if (!in_ready) begin
                n_vec++;
                n_err++;
                $display("FAIL load_handshake: in_ready %b want 1 at slice %0d", in_ready, z);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid  = 1'b0;
        page_last = 1'b0;
        data_in   = 25'd0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d slices outstanding want 0", sb.size());
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_quiet(input string name);
        n_vec++;
        if ({in_ready, out_valid, one_done, done, data_out} !== 29'd0) begin
            n_err++;
            $display("FAIL %s: got rdy %b vld %b od %b done %b data %h want all 0",
                     name, in_ready, out_valid, one_done, done, data_out);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; data_in = 25'd0; page_last = 1'b0;
        #2;
        check_quiet("reset_state");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // all-zero page, final
        clear_page();
        do_start();
        send_page(1, -1, 0, -1, -1);
        drain();

        // slice 1 bit 1, lane (1,0) r=1 -> output slice 0 bit 1
        clear_page();
        page_in[1]  = 25'h000_0002;
        page_exp[0] = 25'h000_0002;
        do_start();
        send_page(1, -1, 0, -1, -1);
        drain();

        // slice 0 bit 2, lane (2,0) r=62 -> output slice 2 bit 2 (wraps)
        clear_page();
        page_in[0]  = 25'h000_0004;
        page_exp[2] = 25'h000_0004;
        do_start();
        send_page(1, -1, 0, -1, -1);
        drain();

        // two pages, 3-cycle stall mid-page on the first
        do_start();
        rotate_random();
        send_page(0, 20, 3, -1, -1);
        rotate_random();
        send_page(1, -1, 0, -1, -1);
        drain();

        // stray start and early page_last on the first page are ignored
        do_start();
        rotate_random();
        send_page(0, -1, 0, 5, 10);
        rotate_random();
        send_page(1, -1, 0, -1, -1);
        drain();

        // reset while slice 10 is being emitted, then a fresh full page
        do_start();
        rotate_random();
        send_page(1, -1, 0, -1, -1);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check_quiet("reset_mid_emit");
        sb.delete();
        @(posedge clk); #1;
        check_quiet("reset_held");
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check_quiet("after_reset_idle");
        do_start();
        rotate_random();
        send_page(1, -1, 0, -1, -1);
        drain();

        // IDLE ignores in_valid without start
        in_valid = 1'b1;
        data_in  = 25'h1ff_ffff;
        repeat (3) begin
            @(posedge clk); #1;
            check_quiet("idle_ignores_valid");
        end
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        n_vec++;
        if (n_done != 6) begin
            n_err++;
            $display("FAIL done_count: got %0d want 6", n_done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
